timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 4, giving the number of independent timer channels (1..16).
REQ-002 The block SHALL take parameter TW, default 32, giving the counter and data width (8..32).
REQ-003 The block SHALL take parameter PW, default 8, giving the prescaler width.
REQ-004 Port clk, input, 1: the clock.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Port csr_we, input, 1: write strobe.
REQ-007 Port csr_waddr, input, 6: write address, [5:2]=channel, [1:0]=offset.
REQ-008 Port csr_wdata, input, TW: write data.
REQ-009 Port csr_re, input, 1: read enable.
REQ-010 Port csr_raddr, input, 6: read address, same encoding as csr_waddr.
REQ-011 Port csr_rdata, output, TW: combinational read data, zero when csr_re=0.
REQ-012 Port irq, output, NUM_CH: per-channel pending interrupt.
REQ-013 Port irq_any, output, 1: OR of (irq & irq_mask).

Function
REQ-014 Offset 0 (TCFG) SHALL hold bit0=En, bit1=Periodic and bits[TW-1:2]=InitVal; it SHALL be read/write.
REQ-015 Offset 1 (TVAL) SHALL read the channel counter; writes to it SHALL be ignored.
REQ-016 Offset 2 (TICLR) SHALL read 0; writing bit0=1 SHALL clear the channel's irq.
REQ-017 Offset 3 of channel 15 (addr 6'h3F) SHALL be the global CTRL register: [PW-1:0]=prescale value, [PW+15:PW]=irq_mask; the mask portion SHALL be present only when PW+16<=TW, otherwise irq_mask SHALL be all-ones.
REQ-018 Offset 3 of any other channel SHALL read 0 and ignore writes.
REQ-019 Channels >= NUM_CH SHALL read 0 and ignore writes (except CTRL).
REQ-020 A shared prescaler SHALL count 0..prescale and pulse tick on the cycle it equals prescale, then wrap to 0; prescale=0 SHALL make tick=1 every cycle.
REQ-021 A write of CTRL SHALL reset the prescaler count to 0 on the next cycle.
REQ-022 A TCFG write with wdata.En=1 SHALL load the counter with {InitVal,2'b00} on the next edge, regardless of tick.
REQ-023 Otherwise, when En=1, tick=1 and counter != all-ones: if counter=0 and Periodic=1 the counter SHALL reload {InitVal,2'b00}; else it SHALL decrement by 1.
REQ-024 One-shot expiry SHALL wrap the counter 0 -> all-ones and then hold it.
REQ-025 The counter SHALL hold when En=0.
REQ-026 irq[i] SHALL set on the edge where En=1, tick=1 and counter=0.
REQ-027 On a simultaneous set and TICLR clear, set SHALL win.
REQ-028 irq SHALL be registered, so its latency is 1 cycle after the expiring tick.
REQ-029 Reads SHALL return the pre-edge value; a same-cycle read of a written register SHALL return the old value.

Reset
REQ-030 Reset SHALL set TCFG=0, counters=all-ones, irq=0, prescale=0, prescaler count=0 and irq_mask=all-ones.
REQ-031 Reset SHALL have priority over any concurrent write, and a mid-count reset SHALL abort counting with no irq generated.
REQ-032 After reset, csr_rdata, irq and irq_any SHALL all be 0.

Structure
REQ-033 The offset constants (TCFG/TVAL/TICLR/CTRL), the CTRL address and the TCFG bit positions SHALL live in a shared package, timer_pkg.
REQ-034 The per-channel counter plus its irq flop SHALL be the sub-module timer_chan, instantiated NUM_CH times via generate.
REQ-035 The address decode, prescaler, read mux and irq_any SHALL live in the top level.

Verification
REQ-036 Write TCFG ch0=0x0000000B (InitVal=2, periodic, en) with prescale=0 -> TVAL reads 8,7,...,0; irq[0] rises one cycle after 0; the counter reloads to 8.
REQ-037 Write TCFG ch1=0x00000005 (InitVal=1, one-shot) -> counts 4..0, irq[1]=1, TVAL then holds 0xFFFFFFFF indefinitely.
REQ-038 Write CTRL prescale=3 and ch2 InitVal=1 en -> the counter decrements every 4th cycle; irq at about cycle 20 after the write.
REQ-039 With irq[0] pending, write TICLR=1 on the same cycle the periodic counter re-hits 0 -> irq[0] stays 1; a later TICLR clears it.
REQ-040 Write irq_mask=0 with irq[3]=1 -> irq_any=0 while irq[3] stays 1; reset asserted mid-count -> all counters are 0xFFFFFFFF and irq=0.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared CSR map constants for the timer bank
// Purpose: register offsets, the global CTRL address, TCFG bit positions and
//          a small address-split helper used by timer_bank and timer_chan.
// Ports:   none (package).
package timer_pkg;

  // Per-channel register offsets within csr_*addr[1:0]
  localparam logic [1:0] OFF_TCFG  = 2'd0;
  localparam logic [1:0] OFF_TVAL  = 2'd1;
  localparam logic [1:0] OFF_TICLR = 2'd2;
  localparam logic [1:0] OFF_CTRL  = 2'd3;

  // Global control register lives at offset 3 of channel 15
  localparam logic [5:0] CTRL_ADDR = {4'hF, OFF_CTRL};

  // TCFG field positions
  localparam int TCFG_EN_BIT   = 0;
  localparam int TCFG_PER_BIT  = 1;
  localparam int TCFG_INIT_LSB = 2;

  typedef struct packed {
    logic [3:0] ch;
    logic [1:0] off;
  } csr_addr_t;

  function automatic csr_addr_t split_addr(input logic [5:0] addr);
    return csr_addr_t'(addr);
  endfunction

endpackage

// File: rtl/timer_chan.sv
// rtl/timer_chan.sv - one timer channel: TCFG register, down-counter, irq flop
// Purpose: holds the channel configuration, counts down on prescaler ticks,
//          reloads (periodic) or parks at all-ones (one-shot), flags expiry.
// Ports:   clk, reset       - clock, synchronous active-high reset
//          tick             - shared prescaler pulse
//          cfg_we/cfg_wdata - TCFG write strobe and data
//          ticlr            - clear request for the pending irq
//          cfg, cnt         - current TCFG and counter (for readback)
//          irq              - registered pending interrupt
module timer_chan
  import timer_pkg::*;
#(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          cfg_we,
  input  logic [TW-1:0] cfg_wdata,
  input  logic          ticlr,
  output logic [TW-1:0] cfg,
  output logic [TW-1:0] cnt,
  output logic          irq
);

  logic          en;
  logic          periodic;
  logic          expire;
  logic [TW-1:0] reload_val;
  logic [TW-1:0] load_val;

  assign en         = cfg[TCFG_EN_BIT];
  assign periodic   = cfg[TCFG_PER_BIT];
  assign reload_val = {cfg[TW-1:TCFG_INIT_LSB], 2'b00};
  assign load_val   = {cfg_wdata[TW-1:TCFG_INIT_LSB], 2'b00};
  assign expire     = en && tick && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
      cnt <= '1;
      irq <= 1'b0;
    end else begin
      if (cfg_we) begin
        cfg <= cfg_wdata;
      end

      // An enabling TCFG write restarts the count immediately, ignoring tick.
      // All-ones is the parked state after a one-shot has expired.
      if (cfg_we && cfg_wdata[TCFG_EN_BIT]) begin
        cnt <= load_val;
      end else if (en && tick && (cnt != '1)) begin
        if ((cnt == '0) && periodic) begin
          cnt <= reload_val;
        end else begin
          cnt <= cnt - TW'(1);
        end
      end

      // A new expiry outranks a same-cycle clear so no event is lost
      if (expire) begin
        irq <= 1'b1;
      end else if (ticlr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of NUM_CH prescaled down-counting timers with CSRs
// Purpose: CSR decode, shared prescaler, global CTRL (prescale + irq mask),
//          combinational read mux and the masked irq summary.
// Ports:   clk, reset                 - clock, synchronous active-high reset
//          csr_we/csr_waddr/csr_wdata - register write port
//          csr_re/csr_raddr/csr_rdata - register read port (rdata is 0 when idle)
//          irq                        - per-channel pending interrupts
//          irq_any                    - OR of irq & irq_mask
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TW     = 32,
  parameter int PW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_we,
  input  logic [5:0]        csr_waddr,
  input  logic [TW-1:0]     csr_wdata,
  input  logic              csr_re,
  input  logic [5:0]        csr_raddr,
  output logic [TW-1:0]     csr_rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  csr_addr_t waddr_f;
  csr_addr_t raddr_f;
  logic      ctrl_we;

  assign waddr_f = split_addr(csr_waddr);
  assign raddr_f = split_addr(csr_raddr);
  assign ctrl_we = csr_we && (csr_waddr == CTRL_ADDR);

  // Shared prescaler: tick fires when the count reaches prescale
  logic [PW-1:0] prescale;
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else if (ctrl_we) begin
      prescale <= csr_wdata[PW-1:0];
      pre_cnt  <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
    end else begin
      pre_cnt  <= pre_cnt + PW'(1);
    end
  end

  // The mask field only exists when it fits above the prescale field
  logic [15:0]         mask16;
  logic [TW-1:0]       ctrl_rdata;
  logic [NUM_CH-1:0]   irq_mask;

  if (PW + 16 <= TW) begin : g_mask
    logic [15:0] mask_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        mask_q <= '1;
      end else if (ctrl_we) begin
        mask_q <= csr_wdata[PW+15:PW];
      end
    end

    assign mask16     = mask_q;
    assign ctrl_rdata = TW'({mask_q, prescale});
  end else begin : g_nomask
    assign mask16     = '1;
    assign ctrl_rdata = TW'(prescale);
  end

  assign irq_mask = mask16[NUM_CH-1:0];
  assign irq_any  = |(irq & irq_mask);

  // Channels
  logic [TW-1:0] cfg_arr [NUM_CH];
  logic [TW-1:0] cnt_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_we;
    logic ticlr;

    assign cfg_we = csr_we && (waddr_f.ch == 4'(i)) && (waddr_f.off == OFF_TCFG);
    assign ticlr  = csr_we && (waddr_f.ch == 4'(i)) && (waddr_f.off == OFF_TICLR)
                    && csr_wdata[0];

    timer_chan #(
      .TW(TW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .cfg_we   (cfg_we),
      .cfg_wdata(csr_wdata),
      .ticlr    (ticlr),
      .cfg      (cfg_arr[i]),
      .cnt      (cnt_arr[i]),
      .irq      (irq[i])
    );
  end

  // Read mux; TICLR, non-CTRL offset 3 and absent channels all read 0
  always_comb begin
    csr_rdata = '0;
    if (csr_re) begin
      if (csr_raddr == CTRL_ADDR) begin
        csr_rdata = ctrl_rdata;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (raddr_f.ch == 4'(i)) begin
            case (raddr_f.off)
              OFF_TCFG: csr_rdata = cfg_arr[i];
              OFF_TVAL: csr_rdata = cnt_arr[i];
              default:  csr_rdata = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank
module tb_timer_bank;

  logic        clk;
  logic        reset;
  logic        csr_we;
  logic [5:0]  csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_re;
  logic [5:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic [3:0]  irq;
  logic        irq_any;

  int total = 0;
  int bad   = 0;

  timer_bank dut (
    .clk      (clk),
    .reset    (reset),
    .csr_we   (csr_we),
    .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata),
    .csr_re   (csr_re),
    .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata),
    .irq      (irq),
    .irq_any  (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start just after a falling edge; writes land on the next rising edge
  task automatic chk_rd(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    csr_re    = 1'b1;
    csr_raddr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [5:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_waddr = addr;
    csr_wdata = data;
    @(negedge clk);
    csr_we    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_re    = 1'b0;
    csr_raddr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_rdata_idle", csr_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    chk_rd("rst_tval0", 6'h01, 32'hFFFF_FFFF);
    chk_rd("rst_ctrl", 6'h3F, 32'h00FF_FF00);

    // Unmapped locations
    csr_write(6'h14, 32'h0000_000B);
    chk_rd("absent_ch_tcfg", 6'h14, 32'h0);
    chk_rd("absent_ch_tval", 6'h15, 32'h0);
    csr_write(6'h03, 32'hFFFF_FFFF);
    chk_rd("ch0_off3", 6'h03, 32'h0);
    chk_rd("ticlr_reads0", 6'h02, 32'h0);

    // Periodic channel 0, InitVal=2 -> 8..0 then reload
    csr_write(6'h00, 32'h0000_000B);
    for (int k = 8; k >= 0; k--) begin
      chk_rd("ch0_tval", 6'h01, 32'(k));
      check("ch0_irq_low", 32'(irq[0]), 32'h0);
      @(negedge clk);
    end
    check("ch0_irq_set", 32'(irq[0]), 32'h1);
    check("irq_any_set", 32'(irq_any), 32'h1);
    chk_rd("ch0_reload", 6'h01, 32'h8);
    chk_rd("ch0_tcfg_rb", 6'h00, 32'h0000_000B);

    // Clear on the same cycle the counter re-expires: set wins
    repeat (8) @(negedge clk);
    chk_rd("ch0_rehit0", 6'h01, 32'h0);
    csr_write(6'h02, 32'h1);
    check("ch0_set_wins", 32'(irq[0]), 32'h1);
    chk_rd("ch0_reload2", 6'h01, 32'h8);
    csr_write(6'h02, 32'h1);
    check("ch0_cleared", 32'(irq[0]), 32'h0);
    chk_rd("ch0_after_clr", 6'h01, 32'h7);
    csr_write(6'h00, 32'h0);
    chk_rd("ch0_dis", 6'h01, 32'h6);
    repeat (3) @(negedge clk);
    chk_rd("ch0_hold", 6'h01, 32'h6);

    // One-shot channel 1, InitVal=1; same-cycle read returns the old TCFG
    csr_we    = 1'b1;
    csr_waddr = 6'h04;
    csr_wdata = 32'h0000_0005;
    chk_rd("same_cycle_old", 6'h04, 32'h0);
    @(negedge clk);
    csr_we = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      chk_rd("ch1_tval", 6'h05, 32'(k));
      check("ch1_irq_low", 32'(irq[1]), 32'h0);
      @(negedge clk);
    end
    check("ch1_irq_set", 32'(irq[1]), 32'h1);
    chk_rd("ch1_wrapped", 6'h05, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    chk_rd("ch1_parked", 6'h05, 32'hFFFF_FFFF);
    chk_rd("ch1_tcfg_rb", 6'h04, 32'h0000_0005);

    // Prescale=3: channel 2 (InitVal=1) steps every 4th cycle
    csr_write(6'h3F, 32'h00FF_FF03);
    csr_write(6'h08, 32'h0000_0005);
    for (int n = 1; n <= 20; n++) begin
      chk_rd("ch2_tval", 6'h09, (n == 20) ? 32'hFFFF_FFFF : 32'(4 - n / 4));
      if (n == 19) check("ch2_irq_low", 32'(irq[2]), 32'h0);
      if (n == 20) check("ch2_irq_set", 32'(irq[2]), 32'h1);
      if (n < 20) @(negedge clk);
    end
    chk_rd("ctrl_rb", 6'h3F, 32'h00FF_FF03);

    // Channel 3 expires immediately; then exercise the mask
    csr_write(6'h3F, 32'h00FF_FF00);
    csr_write(6'h0C, 32'h0000_0001);
    chk_rd("ch3_loaded0", 6'h0D, 32'h0);
    check("ch3_irq_low", 32'(irq[3]), 32'h0);
    @(negedge clk);
    check("ch3_irq_set", 32'(irq[3]), 32'h1);
    csr_write(6'h3F, 32'h0000_0000);
    check("mask0_irq_any", 32'(irq_any), 32'h0);
    check("mask0_irq3", 32'(irq[3]), 32'h1);
    csr_write(6'h3F, 32'h0000_0800);
    check("mask8_irq_any", 32'(irq_any), 32'h1);

    // Reset mid-count with a concurrent write
    csr_write(6'h00, 32'h0000_0103);
    repeat (3) @(negedge clk);
    chk_rd("ch0_midcount", 6'h01, 32'h0000_00FD);
    reset     = 1'b1;
    csr_we    = 1'b1;
    csr_waddr = 6'h04;
    csr_wdata = 32'h0000_000B;
    @(negedge clk);
    csr_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_rd("post_rst_tval", {4'(c), 2'd1}, 32'hFFFF_FFFF);
    end
    check("post_rst_irq", 32'(irq), 32'h0);
    check("post_rst_irq_any", 32'(irq_any), 32'h0);
    chk_rd("post_rst_tcfg1", 6'h04, 32'h0);
    chk_rd("post_rst_ctrl", 6'h3F, 32'h00FF_FF00);
    repeat (10) @(negedge clk);
    check("post_rst_irq_quiet", 32'(irq), 32'h0);
    chk_rd("post_rst_tval0_hold", 6'h01, 32'hFFFF_FFFF);
    csr_re = 1'b0;
    #1;
    check("post_rst_rdata_idle", csr_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
